// File: rtl/simd_alu_pipe.sv
// rtl/simd_alu_pipe.sv - two-stage packed-SIMD add/sub with per-group saturation and overflow flags
// Optional subtract path: define SIMD_ALU_SUB_EN to build it; otherwise every beat is an add.
module simd_alu_pipe #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   a,
    input  logic [LANES*LANE_W-1:0]   b,
    input  logic [1:0]                width,
    input  logic                      op,
    input  logic                      sgn,
    input  logic                      saturate,
    input  logic                      clr_sticky,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   c,
    output logic [LANES-1:0]          ovf,
    output logic                      sat_sticky
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int LW     = $clog2(LANES);

    // Lane-index mask of a group: lanes sharing all bits above the mask form one group.
    function automatic logic [LW-1:0] grp_mask(input logic [1:0] w);
        case (w)
            2'd0:    grp_mask = '0;
            2'd1:    grp_mask = LW'(1);
            2'd2:    grp_mask = LW'(3);
            default: grp_mask = '1;
        endcase
    endfunction

    logic sub_in;
`ifdef SIMD_ALU_SUB_EN
    assign sub_in = op;
`else
    logic unused_op;
    assign unused_op = op;
    assign sub_in    = 1'b0;
`endif

    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ---------------- Stage 1: lane adders with group-local carry chaining
    logic [LW-1:0]     in_mask;
    logic [DATA_W-1:0] sum_n;
    logic [LANES-1:0]  cout_n;
    logic [LANES-1:0]  sa_n;
    logic [LANES-1:0]  sb_n;
    logic [LANE_W-1:0] lane_a;
    logic [LANE_W-1:0] lane_b;
    logic [LANE_W:0]   lane_s;
    logic              carry;
    logic              cin;

    assign in_mask = grp_mask(width);

    always_comb begin
        sum_n  = '0;
        cout_n = '0;
        sa_n   = '0;
        sb_n   = '0;
        lane_a = '0;
        lane_b = '0;
        lane_s = '0;
        carry  = 1'b0;
        cin    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_a = a[i*LANE_W +: LANE_W];
            lane_b = b[i*LANE_W +: LANE_W] ^ {LANE_W{sub_in}};
            cin    = ((LW'(i) & in_mask) == '0) ? sub_in : carry;
            lane_s = {1'b0, lane_a} + {1'b0, lane_b} + {{LANE_W{1'b0}}, cin};
            sum_n[i*LANE_W +: LANE_W] = lane_s[LANE_W-1:0];
            cout_n[i] = lane_s[LANE_W];
            carry     = lane_s[LANE_W];
            sa_n[i]   = lane_a[LANE_W-1];
            sb_n[i]   = lane_b[LANE_W-1];
        end
    end

    logic [DATA_W-1:0] s1_sum;
    logic [LANES-1:0]  s1_cout;
    logic [LANES-1:0]  s1_sa;
    logic [LANES-1:0]  s1_sb;
    logic [1:0]        s1_width;
    logic              s1_sub;
    logic              s1_sgn;
    logic              s1_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_cout  <= '0;
            s1_sa    <= '0;
            s1_sb    <= '0;
            s1_width <= '0;
            s1_sub   <= 1'b0;
            s1_sgn   <= 1'b0;
            s1_sat   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum   <= sum_n;
                s1_cout  <= cout_n;
                s1_sa    <= sa_n;
                s1_sb    <= sb_n;
                s1_width <= width;
                s1_sub   <= sub_in;
                s1_sgn   <= sgn;
                s1_sat   <= saturate;
            end
        end
    end

    // ---------------- Stage 2: overflow detection and clamping per group
    logic [LW-1:0]     s1_mask;
    logic [LANES-1:0]  sum_msb;
    logic [LANES-1:0]  ovf_n;
    logic [DATA_W-1:0] res_n;
    logic [LW-1:0]     top;
    logic              sgn_ovf;
    logic              uns_ovf;
    logic              neg;
    logic [LANE_W-1:0] clamp;

    assign s1_mask = grp_mask(s1_width);

    always_comb begin
        sum_msb = '0;
        ovf_n   = '0;
        res_n   = '0;
        top     = '0;
        sgn_ovf = 1'b0;
        uns_ovf = 1'b0;
        neg     = 1'b0;
        clamp   = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_msb[i] = s1_sum[i*LANE_W + LANE_W - 1];
        end
        for (int i = 0; i < LANES; i++) begin
            // Every lane judges overflow from the most significant lane of its group.
            top     = LW'(i) | s1_mask;
            sgn_ovf = (s1_sa[top] == s1_sb[top]) && (sum_msb[top] != s1_sa[top]);
            uns_ovf = s1_sub ? !s1_cout[top] : s1_cout[top];
            neg     = s1_sa[top];
            ovf_n[i] = s1_sgn ? sgn_ovf : uns_ovf;
            if (s1_sgn) begin
                if (top == LW'(i))
                    clamp = {neg, {(LANE_W-1){~neg}}};
                else
                    clamp = {LANE_W{~neg}};
            end else begin
                clamp = {LANE_W{~s1_sub}};
            end
            res_n[i*LANE_W +: LANE_W] = (s1_sat && ovf_n[i]) ? clamp
                                                              : s1_sum[i*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            c          <= '0;
            ovf        <= '0;
            sat_sticky <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    c   <= res_n;
                    ovf <= ovf_n;
                end
            end
            // A set on hand-off wins over a same-cycle clear.
            if (out_valid && out_ready && (|ovf))
                sat_sticky <= 1'b1;
            else if (clr_sticky)
                sat_sticky <= 1'b0;
        end
    end

endmodule
